// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbiter types, sizes and the one-hot helper
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - round-robin pick of the first set request at or after ptr
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   rel;

    // Rotating so ptr lands on bit 0 turns round-robin into a fixed lowest-first encode.
    always_comb begin
        rot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rot[k] = req[ptr + SEL_W'(k)];
        end
    end

    always_comb begin
        rel = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                rel = SEL_W'(k);
            end
        end
    end

    assign idx = rel + ptr;
    assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - four-way round-robin arbiter with hold-until-done and watchdog release
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               timeout
);

    localparam int HC_W        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_LAST_I);

    arb_state_t         state, state_d;
    logic [SEL_W-1:0]   ptr, ptr_d;
    logic [HC_W-1:0]    hold_cnt, hold_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [SEL_W-1:0]   sel_d;
    logic               busy_d;
    logic               timeout_d;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;
    logic               wd_hit;
    logic               release_now;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // While granted, sel names the owner, so req[sel] is the owner's request.
    assign wd_hit      = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign release_now = done || !req[sel] || wd_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            hold_cnt <= hold_d;
            grant    <= grant_d;
            sel      <= sel_d;
            busy     <= busy_d;
            timeout  <= timeout_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ARB_IDLE:  if (pick_any)    state_d = ARB_GRANT;
            ARB_GRANT: if (release_now) state_d = ARB_IDLE;
            default:                    state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        grant_d   = grant;
        sel_d     = sel;
        busy_d    = busy;
        timeout_d = 1'b0;
        ptr_d     = ptr;
        hold_d    = hold_cnt;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = onehot_sel(pick_idx);
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            ARB_GRANT: begin
                if (release_now) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = sel + 1'b1;
                    timeout_d = wd_hit && !done && req[sel];
                end else if (hold_cnt != '1) begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
